hazard_ctrl: RTL

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller. Detects load-use hazards, applies
// taken-branch flushes and holds the pipeline while a multi-cycle mult/div
// runs (with a timeout). Optional performance counters are compiled in when
// the macro HAZARD_PERF_EN is defined; otherwise they read as constant 0.
module hazard_ctrl #(
    parameter int unsigned MD_TIMEOUT = 64
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [4:0]  rs_fd,
    input  logic [4:0]  rt_fd,
    input  logic        use_rs_fd,
    input  logic        use_rt_fd,
    input  logic [4:0]  wr_dx,
    input  logic        load_dx,
    input  logic        md_start_x,
    input  logic        md_ready,
    input  logic        branch_taken_x,
    output logic        stall_pc,
    output logic        stall_fd,
    output logic        stall_dx,
    output logic        bubble_dx,
    output logic        bubble_xm,
    output logic        flush_fd,
    output logic        md_busy,
    output logic        md_timeout,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_events
);

    localparam int unsigned CNT_W  = 8;
    localparam int unsigned PERF_W = 32;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MD_TIMEOUT - 1);

    typedef enum logic [0:0] {
        RUN     = 1'b0,
        MD_WAIT = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] md_cnt;
    logic             load_use;
    logic             md_expire;

    // Load-use hazard: F/D reads the register a D/X load is about to write.
    assign load_use = load_dx && (wr_dx != 5'd0) &&
                      ((use_rs_fd && (rs_fd == wr_dx)) ||
                       (use_rt_fd && (rt_fd == wr_dx)));

    // Last permitted wait cycle before the forced exit from MD_WAIT.
    assign md_expire = (md_cnt == CNT_LAST);

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: enter MD_WAIT on an issuing mult/div, leave on ready or timeout.
    always_comb begin
        state_next = state;
        case (state)
            RUN: begin
                if (md_start_x) begin
                    state_next = MD_WAIT;
                end
            end
            MD_WAIT: begin
                if (md_ready || md_expire) begin
                    state_next = RUN;
                end
            end
            default: state_next = RUN;
        endcase
    end

    // Pipeline controls; priority in RUN is mult/div start, then branch, then load-use.
    always_comb begin
        stall_pc  = 1'b0;
        stall_fd  = 1'b0;
        stall_dx  = 1'b0;
        bubble_dx = 1'b0;
        bubble_xm = 1'b0;
        flush_fd  = 1'b0;
        md_busy   = 1'b0;
        if (reset_n) begin
            case (state)
                RUN: begin
                    if (md_start_x) begin
                        stall_pc  = 1'b1;
                        stall_fd  = 1'b1;
                        stall_dx  = 1'b1;
                        bubble_xm = 1'b1;
                    end else if (branch_taken_x) begin
                        flush_fd  = 1'b1;
                        bubble_dx = 1'b1;
                    end else if (load_use) begin
                        stall_pc  = 1'b1;
                        stall_fd  = 1'b1;
                        bubble_dx = 1'b1;
                    end
                end
                MD_WAIT: begin
                    md_busy = 1'b1;
                    if (!md_ready) begin
                        stall_pc  = 1'b1;
                        stall_fd  = 1'b1;
                        stall_dx  = 1'b1;
                        bubble_xm = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Wait counter and sticky timeout flag.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            md_cnt     <= '0;
            md_timeout <= 1'b0;
        end else begin
            if (state == RUN) begin
                if (md_start_x) begin
                    md_cnt <= '0;
                end
            end else if (!md_ready) begin
                if (md_cnt != CNT_MAX) begin
                    md_cnt <= md_cnt + CNT_W'(1);
                end
                if (md_expire) begin
                    md_timeout <= 1'b1;
                end
            end
        end
    end

`ifdef HAZARD_PERF_EN
    // Performance counters: PC-stall cycles and front-end flush events, wrapping.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stall_cycles <= '0;
            flush_events <= '0;
        end else begin
            if (stall_pc) begin
                stall_cycles <= stall_cycles + PERF_W'(1);
            end
            if (flush_fd) begin
                flush_events <= flush_events + PERF_W'(1);
            end
        end
    end
`else
    assign stall_cycles = PERF_W'(0);
    assign flush_events = PERF_W'(0);
`endif

endmodule
